// File: rtl/spi_stream_pkg.sv
// Shared definitions for the SPI stream receiver: SPI mode encodings,
// clock polarity/phase extraction and the input synchroniser depth.
package spi_stream_pkg;

    localparam logic [1:0] SPI_MODE0 = 2'd0;  // CPOL=0, CPHA=0
    localparam logic [1:0] SPI_MODE1 = 2'd1;  // CPOL=0, CPHA=1
    localparam logic [1:0] SPI_MODE2 = 2'd2;  // CPOL=1, CPHA=0
    localparam logic [1:0] SPI_MODE3 = 2'd3;  // CPOL=1, CPHA=1

    // Two metastability stages plus one history stage for edge detection.
    localparam int SYNC_DEPTH = 3;

    function automatic logic mode_cpol(input logic [1:0] mode);
        return mode[1];
    endfunction

    function automatic logic mode_cpha(input logic [1:0] mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// First-word-fall-through receive FIFO. The head word lives in its own
// register so the output holds its last value when the FIFO runs empty.
module spi_rx_fifo
    import spi_stream_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_ready,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [WIDTH-1:0] r_data;

    logic             w_pop;
    logic             w_full;
    logic             w_wr;
    logic [PTR_W-1:0] w_rd_ptr_next;
    logic [LVL_W-1:0] w_level_next;

    assign w_pop         = i_ready & (r_level != '0);
    assign w_full        = (r_level == LVL_W'(DEPTH));
    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign w_wr          = i_push & (~w_full | w_pop);
    assign o_drop        = i_push & ~w_wr;
    assign w_rd_ptr_next = r_rd_ptr + PTR_W'(w_pop);
    assign w_level_next  = r_level + LVL_W'(w_wr) - LVL_W'(w_pop);

    assign o_data  = r_data;
    assign o_valid = (r_level != '0);
    assign o_level = r_level;

    // Storage array write port.
    // NOTE: the array has no reset; contents are only read once written, and
    // leaving it out of reset lets it map onto RAM instead of flops.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: state is updated with <= so every flop sees pre-edge values,
    // matching what the hardware does regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_ptr_next;
            r_level  <= w_level_next;
        end
    end

    // Head register: reload whenever the head entry changes, bypassing the
    // array when the incoming word becomes the new head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if ((w_level_next != '0) && (w_pop || (r_level == '0))) begin
            if (w_wr && (r_wr_ptr == w_rd_ptr_next)) begin
                r_data <= i_push_data;
            end else begin
                r_data <= r_mem[w_rd_ptr_next];
            end
        end
    end

endmodule

// File: rtl/spi_stream_rx.sv
// SPI slave receiver feeding a FWFT FIFO. SPI pins are oversampled on
// sysclk; each completed word is echoed back on MISO during the next word.
module spi_stream_rx
    import spi_stream_pkg::*;
#(
    parameter int WORD_W     = 24,
    parameter int FIFO_DEPTH = 16,
    parameter int SPI_MODE   = 0
) (
    input  logic                          sysclk,
    input  logic                          rst,
    input  logic                          SCLK,
    input  logic                          MOSI,
    input  logic                          CS_n,
    output logic                          MISO,
    output logic [WORD_W-1:0]             m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clr_ovf,
    output logic                          frame_err,
    output logic                          busy
);

    localparam logic [1:0]       MODE     = 2'(SPI_MODE);
    localparam logic             CPOL     = mode_cpol(MODE);
    localparam logic             CPHA     = mode_cpha(MODE);
    localparam int               CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
    localparam int               FLUSH_W  = $clog2(SYNC_DEPTH + 1);

    logic [SYNC_DEPTH-1:0] r_sclk_sync;
    logic [SYNC_DEPTH-1:0] r_cs_sync;
    logic [1:0]            r_mosi_sync;
    logic [FLUSH_W-1:0]    r_flush;
    logic                  r_armed;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [WORD_W-2:0]     r_shift;
    logic                  r_push;
    logic [WORD_W-1:0]     r_push_data;
    logic [WORD_W-1:0]     r_echo;
    logic                  r_frame_err;
    logic                  r_miso;
    logic                  r_overflow;

    logic              w_sclk_s2, w_sclk_s3, w_cs_s2, w_cs_s3, w_mosi_s2;
    logic              w_rise, w_fall, w_sample, w_launch;
    logic              w_cs_rise, w_cs_fall, w_busy, w_flushed, w_drop;
    logic [WORD_W-1:0] w_word;
    logic [CNT_W-1:0]  w_tx_idx;

    assign w_sclk_s2 = r_sclk_sync[SYNC_DEPTH-2];
    assign w_sclk_s3 = r_sclk_sync[SYNC_DEPTH-1];
    assign w_cs_s2   = r_cs_sync[SYNC_DEPTH-2];
    assign w_cs_s3   = r_cs_sync[SYNC_DEPTH-1];
    assign w_mosi_s2 = r_mosi_sync[1];

    assign w_rise    = w_sclk_s2 & ~w_sclk_s3;
    assign w_fall    = ~w_sclk_s2 & w_sclk_s3;
    // Modes 0/3 sample on rising SCLK, modes 1/2 on falling.
    assign w_sample  = (CPOL ^ CPHA) ? w_fall : w_rise;
    assign w_launch  = (CPOL ^ CPHA) ? w_rise : w_fall;
    assign w_cs_rise = w_cs_s2 & ~w_cs_s3;
    assign w_cs_fall = ~w_cs_s2 & w_cs_s3;
    assign w_flushed = (r_flush == FLUSH_W'(SYNC_DEPTH));
    assign w_busy    = r_armed & ~w_cs_s2;
    assign w_word    = {r_shift, w_mosi_s2};
    // Bit of the echo word due on MISO after r_bit_cnt samples of this word.
    assign w_tx_idx  = LAST_BIT - r_bit_cnt;

    assign MISO      = r_miso;
    assign busy      = w_busy;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

    // Input synchronisers; reset to the idle bus (deselected, SCLK at CPOL).
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= {SYNC_DEPTH{CPOL}};
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_DEPTH-2:0], SCLK};
            r_cs_sync   <= {r_cs_sync[SYNC_DEPTH-2:0], CS_n};
            r_mosi_sync <= {r_mosi_sync[0], MOSI};
        end
    end

    // Arm only once the synchronisers hold real pin values and CS_n is seen
    // high, so a frame already running at reset release is ignored.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_flush <= '0;
            r_armed <= 1'b0;
        end else begin
            if (!w_flushed) begin
                r_flush <= r_flush + 1'b1;
            end
            if (w_flushed && w_cs_s2) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Deserialiser: shift on sample edges, hand each full word to the FIFO
    // and keep a copy as the echo word for the next transfer.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_echo      <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_push      <= 1'b0;
            r_frame_err <= r_armed & w_cs_rise & (r_bit_cnt != '0);
            if (!w_busy) begin
                r_bit_cnt <= '0;
            end else if (w_sample) begin
                r_shift <= w_word[WORD_W-2:0];
                if (r_bit_cnt == LAST_BIT) begin
                    r_bit_cnt   <= '0;
                    r_push      <= 1'b1;
                    r_push_data <= w_word;
                    r_echo      <= w_word;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    // MISO driver: MSB at select time for CPHA=0, otherwise on launch edges.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_miso <= 1'b0;
        end else if (!w_busy) begin
            r_miso <= 1'b0;
        end else if (w_cs_fall && !CPHA) begin
            r_miso <= r_echo[WORD_W-1];
        end else if (w_launch) begin
            r_miso <= r_echo[w_tx_idx];
        end
    end

    // Sticky overflow; a fresh drop wins over a simultaneous clear.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    spi_rx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (sysclk),
        .rst         (rst),
        .i_push      (r_push),
        .i_push_data (r_push_data),
        .i_ready     (m_ready),
        .o_data      (m_data),
        .o_valid     (m_valid),
        .o_level     (fifo_level),
        .o_drop      (w_drop)
    );

endmodule

// File: tb/tb_spi_stream_rx.sv
// Directed bench for spi_stream_rx: one instance per SPI mode, SCLK at
// sysclk/4, all stimulus applied on falling sysclk edges.
module tb_spi_stream_rx;

    logic             sysclk = 1'b0;
    logic             rst;
    logic [3:0]       sclk;
    logic [3:0]       mosi;
    logic [3:0]       cs_n;
    logic [3:0]       m_ready;
    logic [3:0]       clr_ovf;
    logic [3:0]       miso;
    logic [3:0]       m_valid;
    logic [3:0]       overflow;
    logic [3:0]       frame_err;
    logic [3:0]       busy;
    logic [3:0][23:0] m_data;
    logic [3:0][4:0]  fifo_level;

    int n_tests = 0;
    int n_fail  = 0;
    int ferr0   = 0;

    always #5 sysclk = ~sysclk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_stream_rx #(
            .WORD_W     (24),
            .FIFO_DEPTH (16),
            .SPI_MODE   (g)
        ) dut (
            .sysclk     (sysclk),
            .rst        (rst),
            .SCLK       (sclk[g]),
            .MOSI       (mosi[g]),
            .CS_n       (cs_n[g]),
            .MISO       (miso[g]),
            .m_data     (m_data[g]),
            .m_valid    (m_valid[g]),
            .m_ready    (m_ready[g]),
            .fifo_level (fifo_level[g]),
            .overflow   (overflow[g]),
            .clr_ovf    (clr_ovf[g]),
            .frame_err  (frame_err[g]),
            .busy       (busy[g])
        );
    end

    // Count sysclk cycles during which instance 0 reports frame_err.
    always @(negedge sysclk) begin
        if (frame_err[0]) ferr0 <= ferr0 + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] word_of(input int i);
        return 24'(i) * 24'h010101;
    endfunction

    task automatic frame_begin(input int m);
        cs_n[m] = 1'b0;
        tick(4);
    endtask

    task automatic frame_end(input int m);
        tick(2);
        cs_n[m] = 1'b1;
        tick(5);
    endtask

    // hook 1: m_valid low 3 cycles after the final sample edge, high at 4.
    // hook 2: pulse clr_ovf in the cycle the word reaches the FIFO.
    task automatic after_sample(input int m, input int hook);
        if (hook == 1) begin
            tick(3);
            check($sformatf("m%0d_valid_at_3", m), m_valid[m], 0);
            tick(1);
            check($sformatf("m%0d_valid_at_4", m), m_valid[m], 1);
        end else if (hook == 2) begin
            tick(3);
            clr_ovf[m] = 1'b1;
            tick(1);
            clr_ovf[m] = 1'b0;
        end else begin
            tick(2);
        end
    endtask

    // Send the top nbits of w MSB first; rx collects MISO per bit.
    task automatic send_word(input int m, input logic [23:0] w, input int nbits,
                             input int hook, output logic [23:0] rx);
        logic [1:0] md;
        md = 2'(m);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!md[0]) begin
                mosi[m] = w[23-i];
                tick(2);
                sclk[m] = ~sclk[m];
                after_sample(m, (i == nbits - 1) ? hook : 0);
                rx[23-i] = miso[m];
                sclk[m] = ~sclk[m];
            end else begin
                sclk[m] = ~sclk[m];
                mosi[m] = w[23-i];
                tick(2);
                sclk[m] = ~sclk[m];
                after_sample(m, (i == nbits - 1) ? hook : 0);
                rx[23-i] = miso[m];
            end
        end
    endtask

    task automatic pop_check(input int m, input string tag, input logic [23:0] exp);
        check(tag, m_data[m], exp);
        m_ready[m] = 1'b1;
        tick(1);
        m_ready[m] = 1'b0;
    endtask

    initial begin
        logic [23:0] rx;
        logic [23:0] tail;

        rst     = 1'b1;
        sclk    = 4'b1100;
        cs_n    = 4'hF;
        mosi    = 4'h0;
        m_ready = 4'h0;
        clr_ovf = 4'h0;
        tick(3);
        rst = 1'b0;
        tick(1);

        check("rst_level",     fifo_level[0], 0);
        check("rst_valid",     m_valid[0],    0);
        check("rst_data",      m_data[0],     0);
        check("rst_overflow",  overflow[0],   0);
        check("rst_frame_err", frame_err[0],  0);
        check("rst_busy",      busy[0],       0);
        check("rst_miso",      miso[0],       0);
        tick(5);

        // Two back-to-back words in one mode-0 frame.
        frame_begin(0);
        check("busy_in_frame", busy[0], 1);
        send_word(0, 24'hA5C3F0, 24, 1, rx);
        check("miso_word1", rx, 24'h000000);
        send_word(0, 24'h123456, 24, 0, rx);
        check("miso_word2", rx, 24'hA5C3F0);
        frame_end(0);
        check("busy_after_frame", busy[0], 0);
        check("level_two", fifo_level[0], 2);
        pop_check(0, "pop_word1", 24'hA5C3F0);
        pop_check(0, "pop_word2", 24'h123456);
        check("empty_valid", m_valid[0], 0);
        check("empty_hold_data", m_data[0], 24'h123456);

        // One word per mode, with exact m_valid latency.
        for (int m = 0; m < 4; m++) begin
            frame_begin(m);
            send_word(m, 24'h800001, 24, 1, rx);
            frame_end(m);
            check($sformatf("m%0d_miso", m), rx, (m == 0) ? 24'h123456 : 24'h000000);
            check($sformatf("m%0d_miso_idle", m), miso[m], 0);
            check($sformatf("m%0d_level", m), fifo_level[m], 1);
            pop_check(m, $sformatf("m%0d_data", m), 24'h800001);
        end

        // Overflow: 17 words into a 16-deep FIFO with no consumer.
        frame_begin(0);
        for (int i = 1; i <= 17; i++) begin
            send_word(0, word_of(i), 24, 0, rx);
        end
        tick(2);
        check("full_level", fifo_level[0], 16);
        check("ovf_set", overflow[0], 1);
        clr_ovf[0] = 1'b1;
        tick(1);
        clr_ovf[0] = 1'b0;
        tick(1);
        check("ovf_cleared", overflow[0], 0);
        send_word(0, word_of(18), 24, 2, rx);
        tick(2);
        check("ovf_clr_vs_drop", overflow[0], 1);
        check("echo_of_dropped", rx, word_of(17));
        frame_end(0);
        clr_ovf[0] = 1'b1;
        tick(1);
        clr_ovf[0] = 1'b0;
        tick(1);
        check("ovf_cleared2", overflow[0], 0);
        for (int i = 1; i <= 16; i++) begin
            pop_check(0, $sformatf("drain_%0d", i), word_of(i));
        end
        check("drained_valid", m_valid[0], 0);

        // Partial word: 10 bits then deselect.
        frame_begin(0);
        send_word(0, 24'hFFFFFF, 10, 0, rx);
        frame_end(0);
        check("frame_err_pulses", ferr0, 1);
        check("partial_level", fifo_level[0], 0);
        frame_begin(0);
        send_word(0, 24'h5A5A5A, 24, 1, rx);
        frame_end(0);
        check("after_err_miso", rx, word_of(18));
        check("after_err_level", fifo_level[0], 1);
        check("after_err_data", m_data[0], 24'h5A5A5A);

        // Reset mid-word with CS_n held low.
        frame_begin(0);
        send_word(0, 24'hC0FFEE, 10, 0, rx);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("midrst_level", fifo_level[0], 0);
        check("midrst_valid", m_valid[0],    0);
        check("midrst_data",  m_data[0],     0);
        check("midrst_busy",  busy[0],       0);
        check("midrst_miso",  miso[0],       0);
        tail = 24'hC0FFEE << 10;
        send_word(0, tail, 14, 0, rx);
        tick(6);
        check("tail_ignored_level", fifo_level[0], 0);
        check("tail_ignored_busy",  busy[0],       0);
        frame_end(0);
        check("midrst_no_frame_err", ferr0, 1);
        frame_begin(0);
        send_word(0, 24'h3C3C3C, 24, 1, rx);
        frame_end(0);
        check("post_rst_miso", rx, 24'h000000);
        check("post_rst_level", fifo_level[0], 1);
        pop_check(0, "post_rst_data", 24'h3C3C3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_stream_rx.md
SPI_STREAM_RX -- requirements
Module: spi_stream_rx

Interface
REQ-001 Parameter WORD_W, default 24, SHALL set SPI word width in bits (8..32; 24 = one RGB888 pixel).
REQ-002 Parameter FIFO_DEPTH, default 16, SHALL set receive FIFO entries (power of 2, 4..256).
REQ-003 Parameter SPI_MODE, default 0, SHALL select CPOL = SPI_MODE[1] and CPHA = SPI_MODE[0].
REQ-004 sysclk  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-high.
REQ-006 SCLK  in  1  SPI clock, asynchronous to sysclk.
REQ-007 MOSI  in  1  SPI data in, MSB first.
REQ-008 CS_n  in  1  SPI chip select, active-low.
REQ-009 MISO  out  1  SPI data out, MSB first.
REQ-010 m_data  out  WORD_W  FIFO head word.
REQ-011 m_valid  out  1  m_data valid.
REQ-012 m_ready  in  1  consumer accepts the word when m_valid & m_ready.
REQ-013 fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-014 overflow  out  1  sticky: a completed word was dropped.
REQ-015 clr_ovf  in  1  single-cycle pulse clearing overflow.
REQ-016 frame_err  out  1  one-cycle pulse: CS_n deasserted with a partial word.
REQ-017 busy  out  1  synchronised CS_n active.

Function
REQ-018 SCLK, MOSI and CS_n SHALL pass through 2-flop synchronisers; edges SHALL be detected from synchroniser stage 2 against a stage-3 copy.
REQ-019 SCLK period SHALL be supported down to 4 sysclk periods; faster SCLK is out of scope.
REQ-020 Sample edge SHALL be rising for modes 0/3 and falling for modes 1/2; the launch edge is the opposite edge.
REQ-021 Each sample edge while busy SHALL shift MOSI into a WORD_W shift register and increment a bit counter.
REQ-022 On the WORD_W-th sample, the word SHALL be pushed to the FIFO and the counter SHALL wrap to 0; back-to-back words within one CS_n frame SHALL be supported.
REQ-023 m_valid SHALL rise exactly 4 sysclk cycles after the final sample edge reaches the SCLK pin, when the FIFO was empty.
REQ-024 FIFO SHALL be first-word-fall-through; m_data SHALL hold its last value while empty.
REQ-025 A push while full SHALL be accepted if a pop occurs in the same cycle; otherwise the word SHALL be dropped and overflow set.
REQ-026 Simultaneous clr_ovf and a new drop SHALL leave overflow set.
REQ-027 Each word's MISO content SHALL be the previously completed word (echo register, updated even on drop); the first word after reset SHALL be all zeros.
REQ-028 CPHA=0: MSB SHALL be driven on MISO within 3 sysclk of CS_n falling; later bits on launch edges. CPHA=1: every bit including the MSB SHALL be driven on launch edges.
REQ-029 MISO SHALL be 0 while CS_n is high.
REQ-030 CS_n rising with bit counter != 0 SHALL discard the partial word, reset the counter, and pulse frame_err; with counter = 0 no pulse.
REQ-031 SCLK edges while CS_n is high SHALL be ignored.

Reset
REQ-032 rst SHALL clear: FIFO pointers, fifo_level=0, m_valid=0, m_data=0, overflow=0, frame_err=0, busy=0, MISO=0, echo register=0, bit counter=0; synchronisers SHALL reset to idle (CS_n=1, SCLK=CPOL).
REQ-033 After rst release the block SHALL ignore SPI traffic until a synchronised CS_n high is seen, so a frame in progress at reset is not partially captured.

Structure
REQ-034 Package spi_stream_pkg SHALL hold mode encodings, CPOL/CPHA extraction functions and the synchroniser depth constant (3).
REQ-035 The FIFO SHALL be the sub-module spi_rx_fifo (parametrised width/depth, FWFT, level output); the rest stays in spi_stream_rx.

Verification
REQ-036 Mode 0, WORD_W=24, SCLK=sysclk/4: send 0xA5C3F0, 0x123456 in one frame -> m_data pops 0xA5C3F0 then 0x123456; MISO returned 0x000000 then 0xA5C3F0.
REQ-037 All 4 modes: send 0x800001 -> received 0x800001 in each mode; m_valid at exactly +4 cycles.
REQ-038 m_ready=0, FIFO_DEPTH=16: send 17 words -> fifo_level=16, overflow=1, word 17 lost; clr_ovf -> overflow=0; drain yields words 1..16 in order.
REQ-039 CS_n raised after 10 bits -> frame_err one-cycle pulse, fifo_level unchanged; next full word received correctly.
REQ-040 rst asserted mid-word with CS_n held low -> all outputs at reset values; remaining bits ignored; next frame after CS_n high received correctly.
